error_angle_bank: RTL and testbench

Parametrised multi-channel successor to the single-axis error-angle counter. Holds CHANNELS signed error-angle counts for the CDU DAC drive, each fed by asynchronous-rate up/down pulse commands. One shared ±1 update path serves the channels round-robin. The bank sits between the computer pulse-command decode and the DAC ladder; saturation, pulse buffering and lost-pulse reporting are new in this generation.

---
 rtl/error_angle_pkg.sv | 46 ++++
 rtl/error_angle_bank_channel.sv | 100 ++++++++++
 rtl/error_angle_bank.sv | 64 ++++++
 tb/tb_error_angle_bank.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/error_angle_pkg.sv
// Shared types and arithmetic helpers for the error-angle bank.
// Count and pending paths both use sat_add for clamping.
package error_angle_pkg;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DN
  } step_t;

  typedef struct packed {
    int   val;
    logic clip;
  } sat_t;

  function automatic int cnt_max(int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int pend_max(int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int step_val(step_t s);
    unique case (s)
      STEP_UP: return 1;
      STEP_DN: return -1;
      default: return 0;
    endcase
  endfunction

  function automatic sat_t sat_add(int a, int d, int lim);
    sat_t r;
    r.val  = a + d;
    r.clip = 1'b0;
    if (r.val > lim) begin
      r.val  = lim;
      r.clip = 1'b1;
    end else if (r.val < -lim) begin
      r.val  = -lim;
      r.clip = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/error_angle_bank_channel.sv
// One error-angle channel: pending accumulator, count,
// sticky loss flag and DAC step strobes.
module error_angle_channel
  import error_angle_pkg::*;
#(
  parameter int WIDTH    = 9,
  parameter int PEND_W   = 3,
  parameter int SATURATE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    clear,
  input  logic                    service,
  input  logic                    pulse_up,
  input  logic                    pulse_dn,
  input  logic                    lost_clr,
  output logic signed [WIDTH-1:0] count,
  output logic                    zero,
  output logic                    at_limit,
  output logic                    lost,
  output logic                    dac_up,
  output logic                    dac_dn
);

  localparam int MAXV  = cnt_max(WIDTH);
  localparam int PMAXV = pend_max(PEND_W);

  logic signed [PEND_W-1:0] pend;
  logic signed [PEND_W-1:0] pend_d;
  logic signed [WIDTH-1:0]  count_d;
  logic                     lost_d;
  logic                     up_d;
  logic                     dn_d;
  logic                     loss;
  step_t                    step;
  int                       sv;
  sat_t                     cr;
  sat_t                     pr;

  // Step selection from pre-pulse pending, then next count/pending/loss.
  always_comb begin
    step = STEP_NONE;
    if (service && int'(pend) > 0) begin
      step = STEP_UP;
    end else if (service && int'(pend) < 0) begin
      step = STEP_DN;
    end
    sv = step_val(step);
    cr = sat_add(int'(count), sv, MAXV);
    pr = sat_add(int'(pend),
                 int'(pulse_up) - int'(pulse_dn) - sv,
                 PMAXV);
    count_d = count;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    loss    = pr.clip;
    pend_d  = PEND_W'(pr.val);
    if (step != STEP_NONE) begin
      if (SATURATE != 0 && cr.clip) begin
        loss = 1'b1;
      end else begin
        count_d = (SATURATE != 0) ? WIDTH'(cr.val)
                                  : count + WIDTH'(sv);
        up_d    = (step == STEP_UP);
        dn_d    = (step == STEP_DN);
      end
    end
    lost_d = loss | (lost & ~lost_clr);
    if (!enable || clear) begin
      count_d = '0;
      pend_d  = '0;
      up_d    = 1'b0;
      dn_d    = 1'b0;
      lost_d  = lost & ~lost_clr;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      pend   <= '0;
      lost   <= 1'b0;
      dac_up <= 1'b0;
      dac_dn <= 1'b0;
    end else begin
      count  <= count_d;
      pend   <= pend_d;
      lost   <= lost_d;
      dac_up <= up_d;
      dac_dn <= dn_d;
    end
  end

  assign zero     = (count == '0);
  assign at_limit = (int'(count) == MAXV) ||
                    (int'(count) == -MAXV);

endmodule

// File: rtl/error_angle_bank.sv
// Bank of error-angle channels sharing one round-robin
// +/-1 update slot selected by the scan pointer.
module error_angle_bank
  import error_angle_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 9,
  parameter int PEND_W   = 3,
  parameter int SATURATE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       clear,
  input  logic [CHANNELS-1:0]       pulse_up,
  input  logic [CHANNELS-1:0]       pulse_dn,
  input  logic                      lost_clr,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       zero,
  output logic [CHANNELS-1:0]       at_limit,
  output logic [CHANNELS-1:0]       lost,
  output logic [CHANNELS-1:0]       dac_up,
  output logic [CHANNELS-1:0]       dac_dn
);

  localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [PTR_W-1:0] ptr;

  // Scan pointer: one channel serviced per cycle, wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (ptr == PTR_W'(CHANNELS - 1)) begin
      ptr <= '0;
    end else begin
      ptr <= ptr + 1'b1;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    error_angle_channel #(
      .WIDTH   (WIDTH),
      .PEND_W  (PEND_W),
      .SATURATE(SATURATE)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable[c]),
      .clear   (clear[c]),
      .service (ptr == PTR_W'(c)),
      .pulse_up(pulse_up[c]),
      .pulse_dn(pulse_dn[c]),
      .lost_clr(lost_clr),
      .count   (count[c*WIDTH +: WIDTH]),
      .zero    (zero[c]),
      .at_limit(at_limit[c]),
      .lost    (lost[c]),
      .dac_up  (dac_up[c]),
      .dac_dn  (dac_dn[c])
    );
  end

endmodule

// File: tb/tb_error_angle_bank.sv
// Bench for error_angle_bank: two configurations (saturating
// 9-bit, wrapping 4-bit) driven together against a plain model.
module tb_error_angle_bank;

  localparam int CH = 3;
  localparam int PMAX = 3;
  localparam int WID [2] = '{9, 4};
  localparam int SAT [2] = '{1, 0};

  logic clk = 1'b0;
  logic rst;
  logic [CH-1:0] enable, clear, pulse_up, pulse_dn;
  logic lost_clr;

  logic [CH*9-1:0] count_a;
  logic [CH*4-1:0] count_b;
  logic [CH-1:0] zero_a, lim_a, lost_a, up_a, dn_a;
  logic [CH-1:0] zero_b, lim_b, lost_b, up_b, dn_b;

  int checks = 0;
  int errors = 0;
  bit armed = 0;
  int nup0 = 0;

  int mcnt [2][CH];
  int mp [2][CH];
  bit mlost [2][CH];
  bit mup [2][CH];
  bit mdn [2][CH];
  int mptr;

  always #5 clk = ~clk;

  error_angle_bank #(.CHANNELS(CH), .WIDTH(9),
                     .PEND_W(3), .SATURATE(1)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .pulse_up(pulse_up), .pulse_dn(pulse_dn),
    .lost_clr(lost_clr), .count(count_a), .zero(zero_a),
    .at_limit(lim_a), .lost(lost_a),
    .dac_up(up_a), .dac_dn(dn_a));

  error_angle_bank #(.CHANNELS(CH), .WIDTH(4),
                     .PEND_W(3), .SATURATE(0)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .pulse_up(pulse_up), .pulse_dn(pulse_dn),
    .lost_clr(lost_clr), .count(count_b), .zero(zero_b),
    .at_limit(lim_b), .lost(lost_b),
    .dac_up(up_b), .dac_dn(dn_b));

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int wrapv(input int x, input int w);
    int m;
    int r;
    m = 1 << w;
    r = (x + m / 2) % m;
    if (r < 0) r += m;
    return r - m / 2;
  endfunction

  function automatic int cnt_a(input int c);
    return int'($signed(count_a[c*9 +: 9]));
  endfunction

  function automatic int cnt_b(input int c);
    return int'($signed(count_b[c*4 +: 4]));
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < CH; c++) begin
        int mx;
        int s;
        int nc;
        int np;
        bit loss;
        mx = (1 << (WID[k] - 1)) - 1;
        mup[k][c] = 0;
        mdn[k][c] = 0;
        if (rst) begin
          mcnt[k][c] = 0;
          mp[k][c] = 0;
          mlost[k][c] = 0;
        end else if (!enable[c] || clear[c]) begin
          mcnt[k][c] = 0;
          mp[k][c] = 0;
          if (lost_clr) mlost[k][c] = 0;
        end else begin
          loss = 0;
          s = 0;
          if (mptr == c)
            s = (mp[k][c] > 0) ? 1 : (mp[k][c] < 0) ? -1 : 0;
          if (s != 0) begin
            nc = mcnt[k][c] + s;
            if (SAT[k] == 1 && (nc > mx || nc < -mx)) begin
              loss = 1;
            end else begin
              mcnt[k][c] = wrapv(nc, WID[k]);
              mup[k][c] = (s > 0);
              mdn[k][c] = (s < 0);
            end
          end
          np = mp[k][c] + int'(pulse_up[c])
               - int'(pulse_dn[c]) - s;
          if (np > PMAX) begin np = PMAX; loss = 1; end
          if (np < -PMAX) begin np = -PMAX; loss = 1; end
          mp[k][c] = np;
          mlost[k][c] = loss | (mlost[k][c] & !lost_clr);
        end
      end
    end
    mptr = rst ? 0 : (mptr + 1) % CH;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    pulse_up = '0;
    pulse_dn = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input int c, input bit u, input bit d);
    pulse_up[c] = u;
    pulse_dn[c] = d;
    tick();
    pulse_up = '0;
    pulse_dn = '0;
  endtask

  task automatic clear_all();
    clear = '1;
    tick();
    clear = '0;
  endtask

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        logic [CH-1:0] ez, el, elo, eu, ed;
        int mx;
        mx = (1 << (WID[k] - 1)) - 1;
        for (int c = 0; c < CH; c++) begin
          ez[c] = (mcnt[k][c] == 0);
          el[c] = (mcnt[k][c] == mx) || (mcnt[k][c] == -mx);
          elo[c] = mlost[k][c];
          eu[c] = mup[k][c];
          ed[c] = mdn[k][c];
          chk($sformatf("cfg%0d count%0d", k, c),
              (k == 0) ? cnt_a(c) : cnt_b(c), mcnt[k][c]);
        end
        chk($sformatf("cfg%0d zero", k),
            int'((k == 0) ? zero_a : zero_b), int'(ez));
        chk($sformatf("cfg%0d at_limit", k),
            int'((k == 0) ? lim_a : lim_b), int'(el));
        chk($sformatf("cfg%0d lost", k),
            int'((k == 0) ? lost_a : lost_b), int'(elo));
        chk($sformatf("cfg%0d dac_up", k),
            int'((k == 0) ? up_a : up_b), int'(eu));
        chk($sformatf("cfg%0d dac_dn", k),
            int'((k == 0) ? dn_a : dn_b), int'(ed));
      end
      if (up_a[0] === 1'b1) nup0++;
    end
  end

  initial begin
    int base;
    rst = 1'b1;
    enable = '1;
    clear = '0;
    pulse_up = '0;
    pulse_dn = '0;
    lost_clr = 1'b0;
    mptr = 0;
    tick();
    tick();
    armed = 1;
    chk("reset zero", int'(zero_a), 7);
    chk("reset count", int'(count_a), 0);
    chk("reset lost", int'(lost_a), 0);
    chk("reset dac", int'({up_a, dn_a}), 0);
    rst = 1'b0;

    // Spaced pulses on ch0.
    base = nup0;
    for (int i = 0; i < 5; i++) begin
      pulse(0, 1, 0);
      idle(3);
    end
    idle(6);
    chk("spaced count0", cnt_a(0), 5);
    chk("spaced count0 wrapcfg", cnt_b(0), 5);
    chk("spaced dac_up0", nup0 - base, 5);
    chk("spaced lost", int'(lost_a), 0);
    chk("spaced others", cnt_a(1) + cnt_a(2), 0);
    clear_all();

    // Overdriven ch1: pending clamps, loss reported.
    pulse_up[1] = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    pulse_up = '0;
    chk("burst lost1", int'(lost_a[1]), 1);
    idle(12);
    chk("burst drained count1", cnt_a(1), 10);
    lost_clr = 1'b1;
    tick();
    lost_clr = 1'b0;
    clear_all();

    // Saturation at +MAX on ch2.
    for (int i = 0; i < 256; i++) begin
      pulse(2, 1, 0);
      idle(2);
    end
    idle(10);
    chk("sat count2", cnt_a(2), 255);
    chk("sat at_limit2", int'(lim_a[2]), 1);
    chk("sat lost2", int'(lost_a[2]), 1);
    lost_clr = 1'b1;
    tick();
    lost_clr = 1'b0;
    pulse(2, 0, 1);
    idle(5);
    chk("sat dn count2", cnt_a(2), 254);
    chk("sat lost2 cleared", int'(lost_a[2]), 0);
    clear_all();

    // Wrap behaviour in the 4-bit configuration.
    for (int i = 0; i < 7; i++) begin
      pulse(0, 1, 0);
      idle(3);
    end
    idle(5);
    chk("wrap count 7", cnt_b(0), 7);
    pulse(0, 1, 0);
    idle(5);
    chk("wrap to -8", int'(count_b[3:0]), 8);
    chk("sat cfg 8", cnt_a(0), 8);
    clear_all();
    pulse(0, 0, 1);
    idle(5);
    chk("wrap -1", int'(count_b[3:0]), 15);
    chk("sat cfg -1", cnt_a(0), -1);
    clear_all();

    // Cancelling pulses, then clear with pending.
    pulse(0, 1, 1);
    idle(5);
    chk("cancel count0", cnt_a(0), 0);
    pulse_up[0] = 1'b1;
    tick();
    tick();
    pulse_up = '0;
    clear[0] = 1'b1;
    tick();
    clear = '0;
    idle(5);
    chk("clear count0", cnt_a(0), 0);
    chk("clear zero0", int'(zero_a[0]), 1);

    // Disabled channel ignores pulses.
    enable[0] = 1'b0;
    pulse_up[0] = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    pulse_up = '0;
    idle(3);
    chk("disabled count0", cnt_a(0), 0);
    enable = '1;

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++) begin
        pulse_up[c] = ($urandom_range(0, 3) == 0);
        pulse_dn[c] = ($urandom_range(0, 4) == 0);
        clear[c] = ($urandom_range(0, 99) == 0);
        enable[c] = ($urandom_range(0, 59) != 0);
      end
      lost_clr = ($urandom_range(0, 31) == 0);
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0;
    clear = '0;
    enable = '1;
    lost_clr = 1'b0;
    clear_all();

    // Reset in the middle of a drain.
    pulse_up = 3'b011;
    for (int i = 0; i < 6; i++) tick();
    pulse_up = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst count", int'(count_a), 0);
    chk("midrst zero", int'(zero_a), 7);
    chk("midrst lost", int'(lost_a), 0);
    pulse(1, 1, 0);
    idle(3);
    chk("midrst ptr restart count1", cnt_a(1), 1);
    idle(4);

    armed = 0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
